// File: rtl/relu_maxpool2.sv
// Requantise conv2 results, apply optional ReLU, and 2x2 stride-2 max-pool in raster order.
// Define RELU_MAXPOOL2_RELU_EN to clamp negative activations to zero before pooling.
module relu_maxpool2 #(
  parameter int unsigned DATA_W = 30,
  parameter int unsigned OUT_W  = 22,
  parameter int unsigned SHIFT  = 8,
  parameter int unsigned MAP_W  = 8,
  parameter int unsigned MAP_H  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              done_pool
);

  localparam int unsigned CW     = (MAP_W > 1) ? $clog2(MAP_W) : 1;
  localparam int unsigned RW     = (MAP_H > 1) ? $clog2(MAP_H) : 1;
  localparam int unsigned HALF_W = MAP_W / 2;
  localparam int unsigned LW     = (HALF_W > 1) ? $clog2(HALF_W) : 1;

  localparam logic signed [DATA_W-1:0] SAT_MAX = {{(DATA_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] SAT_MIN = {{(DATA_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  function automatic logic signed [OUT_W-1:0] smax(input logic signed [OUT_W-1:0] a,
                                                  input logic signed [OUT_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  logic [CW-1:0]           col_q, col_d, eff_col;
  logic [RW-1:0]           row_q, row_d, eff_row;
  logic signed [OUT_W-1:0] hold_q, hold_d;
  logic signed [OUT_W-1:0] linebuf_q [HALF_W];
  logic [OUT_W-1:0]        out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;
  logic                    last_q, last_d;
  logic                    done_q, done_d;

  logic signed [DATA_W-1:0] shifted;
  logic signed [OUT_W-1:0]  sat_val, r_val, pair_max, quad_max;
  logic                     accept, emit, lb_we, last_pix;
  logic [LW-1:0]            lb_idx;

  assign in_ready  = !out_valid_q || out_ready;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign done_pool = done_q;

  assign accept = in_valid && in_ready;

  // A pixel accepted together with start is placed at (0,0).
  assign eff_col = start ? '0 : col_q;
  assign eff_row = start ? '0 : row_q;

  always_comb begin
    shifted = $signed(in_data) >>> SHIFT;
    if (shifted > SAT_MAX) begin
      sat_val = SAT_MAX[OUT_W-1:0];
    end else if (shifted < SAT_MIN) begin
      sat_val = SAT_MIN[OUT_W-1:0];
    end else begin
      sat_val = shifted[OUT_W-1:0];
    end
  end

`ifdef RELU_MAXPOOL2_RELU_EN
  assign r_val = sat_val[OUT_W-1] ? '0 : sat_val;
`else
  assign r_val = sat_val;
`endif

  assign lb_idx   = LW'(eff_col >> 1);
  assign pair_max = smax(hold_q, r_val);
  assign quad_max = smax(linebuf_q[lb_idx], pair_max);
  assign lb_we    = accept && !eff_row[0] && eff_col[0];
  assign emit     = accept && eff_row[0] && eff_col[0];
  assign last_pix = (eff_col == CW'(MAP_W - 1)) && (eff_row == RW'(MAP_H - 1));

  always_comb begin
    col_d  = eff_col;
    row_d  = eff_row;
    hold_d = start ? '0 : hold_q;
    if (accept) begin
      if (!eff_col[0]) begin
        hold_d = r_val;
      end
      if (eff_col == CW'(MAP_W - 1)) begin
        col_d = '0;
        row_d = (eff_row == RW'(MAP_H - 1)) ? '0 : eff_row + 1'b1;
      end else begin
        col_d = eff_col + 1'b1;
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    last_d      = last_q;
    if (out_ready) begin
      out_valid_d = 1'b0;
    end
    if (emit) begin
      out_valid_d = 1'b1;
      out_data_d  = quad_max;
      last_d      = last_pix;
    end
    if (start) begin
      out_valid_d = 1'b0;
    end
    done_d = !start && out_valid_q && out_ready && last_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      hold_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      last_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      hold_q      <= hold_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      last_q      <= last_d;
      done_q      <= done_d;
    end
  end

  // Line buffer holds the even-row pair maxima; contents need no reset.
  always_ff @(posedge clk) begin
    if (lb_we) begin
      linebuf_q[lb_idx] <= pair_max;
    end
  end

endmodule

// File: doc/relu_maxpool2.md
Name: relu_maxpool2

Overview:
- Streaming stage directly downstream of conv2. Consumes one 30-bit signed conv2 result per handshake, in raster order over a MAP_W x MAP_H feature map.
- Quantises each value back to the 22-bit activation format, applies ReLU, and performs 2x2 stride-2 max pooling using a half-width line buffer.
- Emits pooled activations with valid/ready backpressure to the next conv/FC stage, and pulses done_pool at frame end.

Parameters:
- DATA_W, 30, input width (conv2 output width)
- OUT_W, 22, output activation width (conv2 input element width)
- SHIFT, 8, arithmetic right-shift applied before saturation
- MAP_W, 8, feature-map width in pixels; even, >=2
- MAP_H, 8, feature-map height in pixels; even, >=2

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; synchronously clears counters and frame state
- in_data  in  DATA_W  signed conv2 result (output4)
- in_valid  in  1  in_data valid (driven from done_conv2)
- in_ready  out  1  stage can accept in_data this cycle
- out_data  out  OUT_W  signed pooled activation
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts out_data
- done_pool  out  1  one-cycle pulse when the last pooled output of a frame is accepted

Behaviour:
- Reset (rst_n=0, async): out_data=0, out_valid=0, done_pool=0, col=0, row=0, hold register=0. Line buffer contents are don't-care.
- in_ready = !out_valid || out_ready (combinational). An input is accepted on a cycle where in_valid && in_ready.
- Quantise: q = in_data >>> SHIFT (arithmetic). Saturate q to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. Then r = ReLU(q): negative values become 0.
- Counters:
  - col increments per accepted input and wraps at MAP_W-1 to 0.
  - On each col wrap, row increments; row wraps at MAP_H-1 to 0.
- Even row:
  - Even col: hold <= r.
  - Odd col: linebuf[col/2] <= max(hold, r).
- Odd row:
  - Even col: hold <= r.
  - Odd col: out_data <= max(linebuf[col/2], hold, r) and out_valid <= 1. The output register is visible the cycle after acceptance (latency 1).
- out_valid stays high with out_data stable until out_ready is sampled high. It then clears unless a new pooled result loads in the same cycle, in which case it stays high with the new data.
- done_pool <= 1 for exactly one cycle when the output for the last block of the frame (row MAP_H-1, col MAP_W-1) is accepted downstream. After that, col and row are 0 and the next frame proceeds with no start required.
- start takes precedence: it clears col, row, hold, out_valid and done_pool. An input accepted in the same cycle as start is treated as pixel (0,0).
- Frame geometry: (MAP_W/2)*(MAP_H/2) outputs per MAP_W*MAP_H inputs.
- Comparisons are signed at OUT_W bits. Ties are irrelevant because values are equal.

Optional Feature:
- Macro: RELU_MAXPOOL2_RELU_EN.
- Defined: ReLU is applied as above; all outputs are >= 0.
- Undefined: no ReLU. Pooling is a signed max over saturated q, so outputs may be negative, down to -2^(OUT_W-1).

Test Plan:
- Reset mid-frame: assert rst_n=0 after 5 inputs -> out_valid=0 and done_pool=0 immediately. A subsequent full frame pools correctly from (0,0).
- MAP_W=4, MAP_H=4, SHIFT=0, inputs 1..16 in raster order, out_ready=1 -> outputs 6, 8, 14, 16 in that order; done_pool pulses once, with the output of 16.
- Saturation: in_data=30'sh1FFF_FFFF with SHIFT=8 -> out_data=22'sh1FFFFF. With RELU_MAXPOOL2_RELU_EN defined, in_data=-1000 -> 0.
- Backpressure: hold out_ready=0 after the first output -> in_ready=0, out_data stable. Release after 10 cycles -> no data lost and order preserved.
- start asserted at pixel index 7 together with in_valid -> that pixel is counted as (0,0); the old partial frame produces no output.
- Optional feature off: 2x2 block {-5,-3,-9,-7} with SHIFT=0 -> out_data=-3.
